// File: rtl/fetch_pkg.sv
// Shared types for the fetch queue: FSM state encoding and the buffered {pc, instr} entry.
// Default widths below match the 64-bit PC / 32-bit instruction configuration.
package fetch_pkg;
    localparam int FETCH_N  = 64;
    localparam int FETCH_IW = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_N-1:0]  pc;
        logic [FETCH_IW-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/adder.sv
// Plain W-bit adder; the carry out is dropped so the PC wraps modulo 2^W.
module adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a + b;
endmodule

// File: rtl/fetch_fifo.sv
// Circular-buffer FIFO with wrap-around pointers, flush, and occupancy count.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 96
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push, do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty && !flush;
    // A push into a full queue is only legal when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = mem[rd_ptr_reg];
    assign count   = count_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mux2.sv
// Two-input W-bit multiplexer: s=0 selects d0, s=1 selects d1.
module mux2 #(
    parameter int W = 64
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         s,
    output logic [W-1:0] y
);
    assign y = s ? d1 : d0;
endmodule

// File: rtl/fetch_queue.sv
// Fetch stage with a single-outstanding request to a variable-latency instruction
// memory and a DEPTH-entry {pc, instr} queue drained by decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int           N        = FETCH_N,
    parameter int           IW       = FETCH_IW,
    parameter int           DEPTH    = 4,
    parameter logic [N-1:0] RESET_PC = '0,
    parameter logic [N-1:0] PC_STEP  = N'(4)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PCSrc_F,
    input  logic [N-1:0]               PCBranch_F,
    output logic                       imem_req_valid,
    input  logic                       imem_req_ready,
    output logic [N-1:0]               imem_addr_F,
    input  logic                       imem_rsp_valid,
    input  logic [IW-1:0]              imem_rsp_data,
    output logic                       instr_valid_D,
    input  logic                       instr_ready_D,
    output logic [IW-1:0]              instr_D,
    output logic [N-1:0]               pc_D,
    output logic [$clog2(DEPTH+1)-1:0] queue_count
);
    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t  state_reg, state_next;
    logic [N-1:0]  pc_reg, pc_next, pc_plus, pc_seq;
    logic [N-1:0]  addr_reg, addr_next;
    logic          stale_reg, stale_next;
    logic          req_accept, rsp_take, push, pop_eff, advance, space;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] count_next;
    logic [N+IW-1:0] fifo_rdata;

    assign req_accept = (state_reg == REQ) && imem_req_ready;
    assign rsp_take   = (state_reg == WAIT) && imem_rsp_valid;
    assign push       = rsp_take && !stale_reg && !PCSrc_F;
    assign pop_eff    = instr_ready_D && !fifo_empty;
    assign count_next = PCSrc_F ? '0 : (queue_count + CW'(push) - CW'(pop_eff));
    // Occupancy can only drop while a request is outstanding, so a slot
    // reserved here is still free when the response lands.
    assign space      = (count_next < CW'(DEPTH));
    // A request accepted after a redirect carries the old address; the PC must stay on target.
    assign advance    = req_accept && !stale_reg;

    adder #(.W(N)) u_pc_adder (
        .a (pc_reg),
        .b (PC_STEP),
        .y (pc_plus)
    );

    mux2 #(.W(N)) u_seq_mux (
        .d0 (pc_reg),
        .d1 (pc_plus),
        .s  (advance),
        .y  (pc_seq)
    );

    mux2 #(.W(N)) u_redirect_mux (
        .d0 (pc_seq),
        .d1 (PCBranch_F),
        .s  (PCSrc_F),
        .y  (pc_next)
    );

    always_comb begin
        state_next = state_reg;
        stale_next = stale_reg;
        addr_next  = addr_reg;
        unique case (state_reg)
            IDLE: begin
                if (space) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem_req_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = space ? REQ : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (rsp_take) begin
            stale_next = 1'b0;
        end else if (PCSrc_F && (state_reg != IDLE)) begin
            stale_next = 1'b1;
        end

        // The presented address is frozen from entry into REQ until the response returns.
        if ((state_reg == IDLE) || rsp_take) begin
            addr_next = pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            pc_reg    <= RESET_PC;
            addr_reg  <= RESET_PC;
            stale_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            addr_reg  <= addr_next;
            stale_reg <= stale_next;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH), .W(N+IW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (instr_ready_D),
        .flush (PCSrc_F),
        .wdata ({addr_reg, imem_rsp_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (queue_count)
    );

    assign imem_req_valid = (state_reg == REQ);
    assign imem_addr_F    = addr_reg;
    assign instr_valid_D  = !fifo_empty;
    assign pc_D           = fifo_rdata[N+IW-1:IW];
    assign instr_D        = fifo_rdata[IW-1:0];

    no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(push && fifo_full && !pop_eff));
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Holds the PC and issues requests to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned {pc, instr} pairs in a DEPTH-entry queue drained by decode through a valid/ready handshake.
- A branch redirect (PCSrc_F) reloads the PC, flushes the queue and discards any in-flight response.

Parameters:
N, 64, address/PC width
IW, 32, instruction width
DEPTH, 4, queue entries (power of 2, >=2)
RESET_PC, 0, PC value loaded at reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low: reset==0 at a rising clk edge resets the block
PCSrc_F  in  1  redirect request
PCBranch_F  in  N  redirect target
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_addr_F  out  N  request address
imem_rsp_valid  in  1  response valid (single cycle, no backpressure)
imem_rsp_data  in  IW  fetched instruction
instr_valid_D  out  1  queue head valid
instr_ready_D  in  1  decode consumes head
instr_D  out  IW  head instruction
pc_D  out  N  head PC
queue_count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset values: PC=RESET_PC, state=IDLE, stale=0, queue empty; imem_req_valid=0, imem_addr_F=RESET_PC, instr_valid_D=0, queue_count=0. Reset overrides every other input in that cycle.
- At most one request is outstanding at any time.
- FSM states:
  - IDLE: imem_req_valid=0. Goes to REQ when count_next < DEPTH.
  - REQ: imem_req_valid=1, imem_addr_F=PC. On accept (valid&ready) goes to WAIT, and PC <= PC+PC_STEP (mod 2^N).
  - WAIT: imem_req_valid=0. On imem_rsp_valid, goes to REQ if count_next < DEPTH, else IDLE.
- Request hold rule: once imem_req_valid is asserted, imem_addr_F holds stable until accepted, including across a redirect.
- Response timing:
  - Earliest response is the cycle after accept.
  - imem_rsp_valid outside WAIT is ignored.
  - A non-stale response in WAIT is enqueued as {pc_of_request, imem_rsp_data}.
  - instr_valid_D rises the cycle after enqueue. Minimum latency: accept at t, response at t+1, instr_valid_D at t+2.
- Dequeue: occurs when instr_valid_D & instr_ready_D. Head is updated next cycle. Same-cycle enqueue and dequeue keeps the count unchanged.
- Occupancy rules:
  - count_next is the count after this cycle's enqueue/dequeue.
  - A new request is only issued if its response is guaranteed a free slot, so the queue never overflows.
  - imem_rsp_valid is never dropped for lack of space.
- Redirect (PCSrc_F=1) in any state:
  - PC <= PCBranch_F.
  - Queue flushed (count 0); flush wins over a same-cycle dequeue or enqueue.
  - If state is REQ or WAIT, stale <= 1.
  - IDLE goes to REQ next cycle; REQ/WAIT keep their normal transitions.
- Stale handling:
  - A response arriving while stale=1 is discarded and clears stale.
  - A response arriving in the same cycle as a redirect is discarded, and stale is not set.
  - After the discarded response, the next request uses the redirected PC.
- Redirect while in REQ: the pending (old) address is still presented until accepted, and its response is discarded. The PC advance on that accept is suppressed, so the PC stays at the target.
- Back-to-back redirects: the last target wins; stale remains 1 until one response has been consumed.
- PC wrap: PC+PC_STEP wraps modulo 2^N silently.
- Empty queue: instr_D and pc_D are don't-care while instr_valid_D=0.
- Full queue: instr_valid_D=1 and no request is issued until a dequeue.
- Reset asserted mid-transaction: state returns to IDLE. A late memory response is ignored because the state is not WAIT.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, WAIT}.
  - fetch_entry_t struct {pc[N], instr[IW]}, with default widths as localparams.
- Sub-module fetch_fifo (parameters DEPTH, W):
  - Synchronous, active-low reset.
  - Ports: push/pop/flush, full/empty, count.
  - Implemented as a circular buffer with wrap-around read/write pointers.
- The PC increment uses the existing adder.
- The redirect/next-PC select uses the existing mux2.

Test Plan:
- Reset then ready=1, 1-cycle memory, instr_ready_D=1 -> addresses 0x0, 0x4, 0x8 issued every 2 cycles; first instr_valid_D 2 cycles after first accept with pc_D=0x0.
- instr_ready_D=0 with DEPTH=4 -> exactly 4 requests accepted; queue_count reaches 4; imem_req_valid stays 0 until one dequeue, then request 0x10 issues.
- Redirect to 0x100 while in WAIT for 0x8 -> queue_count=0 next cycle; response for 0x8 discarded; next request address 0x100; first pc_D=0x100.
- imem_req_ready=0 for 3 cycles at address 0xC, redirect to 0x200 in cycle 2 -> address stays 0xC until accepted; its response discarded; next request 0x200.
- RESET_PC=2^64-4 -> requests 0xFFFF_FFFF_FFFF_FFFC then 0x0.
- reset=0 for one cycle while in WAIT, followed by a late imem_rsp_valid -> response ignored; queue_count=0; next request address RESET_PC.
